mesh_loader: RTL

Writer side of the vertex-fetch memories. It accepts a 32-bit word stream from the host-link word assembler and decodes it into index, position and normal entries. It drives the write ports of the three RAMs that vertex fetch reads. It closes each mesh with the 12'hFFF end-of-stream sentinel and raises mesh_ready_out so vertex fetch may be released from reset.

---
 rtl/mesh_pkg.sv | 28 ++
 rtl/entry_assembler.sv | 29 ++
 rtl/mesh_loader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared types and constants for mesh loading and vertex fetch
package mesh_pkg;

  typedef enum logic [1:0] {
    INDEX    = 2'b00,
    POSITION = 2'b01,
    NORMAL   = 2'b10,
    END      = 2'b11
  } target_t;

  typedef enum logic [1:0] {
    S_HEADER,
    S_COLLECT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int HDR_TARGET_LSB = 30;
  localparam int HDR_START_LSB  = 16;
  localparam int HDR_COUNT_LSB  = 0;
  localparam int HDR_FIELD_W    = 12;

  localparam logic [11:0] SENTINEL_ID = 12'hFFF;

  localparam int DEF_INDEX_DEPTH  = 4096;
  localparam int DEF_VERTEX_DEPTH = 1024;

endpackage

// File: rtl/entry_assembler.sv
// rtl/entry_assembler.sv - 3-word shift register that frames stream words into RAM entries
module entry_assembler (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        i_shift,
  input  logic [1:0]  i_words_per_entry,
  input  logic [31:0] i_word,
  output logic        o_entry_done,
  output logic [95:0] o_entry
);

  logic [63:0] r_hist;
  logic [1:0]  r_count;

  // The final word is presented combinationally so the entry is complete in its acceptance cycle.
  assign o_entry_done = i_shift && (r_count == (i_words_per_entry - 2'd1));
  assign o_entry      = {r_hist, i_word};

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_hist  <= 64'd0;
      r_count <= 2'd0;
    end else if (i_shift) begin
      r_hist  <= {r_hist[31:0], i_word};
      r_count <= o_entry_done ? 2'd0 : r_count + 2'd1;
    end
  end

endmodule

// File: rtl/mesh_loader.sv
// rtl/mesh_loader.sv - decodes the host word stream into index/position/normal RAM writes
module mesh_loader
  import mesh_pkg::*;
#(
  parameter int INDEX_DEPTH  = DEF_INDEX_DEPTH,
  parameter int VERTEX_DEPTH = DEF_VERTEX_DEPTH
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] word_in,
  input  logic        word_valid_in,
  output logic        word_ready_out,
  output logic        index_we_out,
  output logic [11:0] index_addr_out,
  output logic [35:0] index_data_out,
  output logic        position_we_out,
  output logic        normal_we_out,
  output logic [9:0]  vertex_addr_out,
  output logic [95:0] vertex_data_out,
  output logic        mesh_ready_out,
  output logic        error_out
);

  localparam logic [13:0] LP_INDEX_LIMIT  = 14'(INDEX_DEPTH);
  localparam logic [13:0] LP_VERTEX_LIMIT = 14'(VERTEX_DEPTH);

  state_t      r_state;
  state_t      w_state_next;
  target_t     r_target;
  logic [11:0] r_addr;
  logic [11:0] r_remaining;

  logic        r_index_we;
  logic        r_position_we;
  logic        r_normal_we;
  logic [11:0] r_index_addr;
  logic [35:0] r_index_data;
  logic [9:0]  r_vertex_addr;
  logic [95:0] r_vertex_data;
  logic        r_mesh_ready;
  logic        r_error;

  logic        w_xfer;
  logic        w_hdr_accept;
  logic        w_collect_shift;
  logic        w_hdr_error;
  logic        w_sentinel;
  logic        w_entry_done;
  target_t     w_hdr_target;
  logic [11:0] w_hdr_start;
  logic [11:0] w_hdr_count;
  logic [13:0] w_hdr_span;
  logic [1:0]  w_words_per_entry;
  logic [95:0] w_entry;
  logic        w_unused_hdr_bits;

  assign word_ready_out  = rst_n_in && ((r_state == S_HEADER) || (r_state == S_COLLECT));
  assign w_xfer          = word_valid_in && word_ready_out;
  assign w_hdr_accept    = w_xfer && (r_state == S_HEADER);
  assign w_collect_shift = w_xfer && (r_state == S_COLLECT);

  assign w_hdr_target      = target_t'(word_in[HDR_TARGET_LSB +: 2]);
  assign w_hdr_start       = word_in[HDR_START_LSB +: HDR_FIELD_W];
  assign w_hdr_count       = word_in[HDR_COUNT_LSB +: HDR_FIELD_W];
  assign w_hdr_span        = {2'b00, w_hdr_start} + {2'b00, w_hdr_count};
  assign w_unused_hdr_bits = ^{word_in[29:28], word_in[15:12]};

  // Whole-command range check up front, so per-entry address increments can never wrap.
  always_comb begin
    w_hdr_error = 1'b0;
    case (w_hdr_target)
      INDEX:           w_hdr_error = (w_hdr_span > LP_INDEX_LIMIT);
      POSITION, NORMAL: w_hdr_error = (w_hdr_span > LP_VERTEX_LIMIT) || (w_hdr_start[11:10] != 2'b00);
      default:         w_hdr_error = ({2'b00, w_hdr_count} >= LP_INDEX_LIMIT);
    endcase
  end

  assign w_words_per_entry = (r_target == INDEX) ? 2'd2 : 2'd3;

  entry_assembler u_entry_assembler (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .i_shift           (w_collect_shift),
    .i_words_per_entry (w_words_per_entry),
    .i_word            (word_in),
    .o_entry_done      (w_entry_done),
    .o_entry           (w_entry)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= S_HEADER;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sentinel   = 1'b0;
    case (r_state)
      S_HEADER: begin
        if (w_hdr_accept) begin
          if (w_hdr_error) begin
            w_state_next = S_ERROR;
          end else if (w_hdr_target == END) begin
            w_state_next = S_DONE;
            w_sentinel   = 1'b1;
          end else if (w_hdr_count != 12'd0) begin
            w_state_next = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (w_entry_done && (r_remaining == 12'd1)) begin
          w_state_next = S_HEADER;
        end
      end
      default: begin
        w_state_next = r_state;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_target      <= INDEX;
      r_addr        <= 12'd0;
      r_remaining   <= 12'd0;
      r_index_we    <= 1'b0;
      r_position_we <= 1'b0;
      r_normal_we   <= 1'b0;
      r_index_addr  <= 12'd0;
      r_index_data  <= 36'd0;
      r_vertex_addr <= 10'd0;
      r_vertex_data <= 96'd0;
      r_mesh_ready  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_index_we    <= 1'b0;
      r_position_we <= 1'b0;
      r_normal_we   <= 1'b0;
      if (w_hdr_accept) begin
        r_target    <= w_hdr_target;
        r_addr      <= w_hdr_start;
        r_remaining <= w_hdr_count;
      end
      // The end command carries its target index address in the count field.
      if (w_sentinel) begin
        r_index_we   <= 1'b1;
        r_index_addr <= w_hdr_count;
        r_index_data <= {SENTINEL_ID, 24'h0};
      end
      if (w_entry_done) begin
        case (r_target)
          INDEX: begin
            r_index_we   <= 1'b1;
            r_index_addr <= r_addr;
            r_index_data <= w_entry[35:0];
          end
          POSITION: begin
            r_position_we <= 1'b1;
            r_vertex_addr <= r_addr[9:0];
            r_vertex_data <= w_entry;
          end
          NORMAL: begin
            r_normal_we   <= 1'b1;
            r_vertex_addr <= r_addr[9:0];
            r_vertex_data <= w_entry;
          end
          default: begin
            r_index_we <= 1'b0;
          end
        endcase
        r_addr      <= r_addr + 12'd1;
        r_remaining <= r_remaining - 12'd1;
      end
      r_mesh_ready <= r_mesh_ready || (r_state == S_DONE);
      r_error      <= r_error || (w_state_next == S_ERROR);
    end
  end

  assign index_we_out    = r_index_we;
  assign index_addr_out  = r_index_addr;
  assign index_data_out  = r_index_data;
  assign position_we_out = r_position_we;
  assign normal_we_out   = r_normal_we;
  assign vertex_addr_out = r_vertex_addr;
  assign vertex_data_out = r_vertex_data;
  assign mesh_ready_out  = r_mesh_ready;
  assign error_out       = r_error;

endmodule
